// File: rtl/iterative_alu.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative N-bit shift,
// shift-add multiply and restoring unsigned divide, one step per RUN cycle.
module iterative_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] d_hi,
    output logic             carry,
    output logic             low,
    output logic             flag,
    output logic             zero,
    output logic             negative
);

    localparam int AMT_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_CMP    = 4'd2;
    localparam logic [3:0] OP_AND    = 4'd3;
    localparam logic [3:0] OP_OR     = 4'd4;
    localparam logic [3:0] OP_XOR    = 4'd5;
    localparam logic [3:0] OP_SHIFT  = 4'd6;
    localparam logic [3:0] OP_SHIFTN = 4'd7;
    localparam logic [3:0] OP_MUL    = 4'd8;
    localparam logic [3:0] OP_DIVU   = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_dir;
    logic               r_c;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   r_d_hi;
    logic               r_carry;
    logic               r_low;
    logic               r_flag;
    logic               r_zero;
    logic               r_negative;

    logic               w_accept;
    logic               w_multi;
    logic               w_last;
    logic [AMT_W-1:0]   w_amt;
    logic [CNT_W-1:0]   w_init_cnt;

    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;

    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;
    logic               w_step_c;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_rem;
    logic [WIDTH:0]     w_div_diff;

    logic [WIDTH-1:0]   w_res_d;
    logic [WIDTH-1:0]   w_res_hi;
    logic               w_res_carry;
    logic               w_res_low;
    logic               w_res_flag;
    logic               w_res_zero;
    logic               w_res_negative;

    assign ready    = (r_state != S_RUN);
    assign done     = (r_state == S_DONE);
    assign d        = r_d;
    assign d_hi     = r_d_hi;
    assign carry    = r_carry;
    assign low      = r_low;
    assign flag     = r_flag;
    assign zero     = r_zero;
    assign negative = r_negative;

    assign w_accept = start && (r_state != S_RUN);
    assign w_amt    = a[AMT_W-1:0];
    assign w_multi  = (op == OP_MUL) || (op == OP_DIVU) ||
                      ((op == OP_SHIFTN) && (w_amt != '0));
    assign w_init_cnt = (op == OP_SHIFTN) ? CNT_W'(w_amt) : CNT_W'(WIDTH);
    assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(1));

    assign w_add = {1'b0, a} + {1'b0, b};
    assign w_sub = {1'b0, a} - {1'b0, b};

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = w_multi ? S_RUN : S_DONE;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // One iteration of the active multi-cycle op
    always_comb begin
        w_step_hi  = r_hi;
        w_step_lo  = r_lo;
        w_step_c   = r_c;
        w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_div_rem  = {r_hi, r_lo[WIDTH-1]};
        w_div_diff = w_div_rem - {1'b0, r_opnd};
        case (r_op)
            OP_MUL: begin
                {w_step_hi, w_step_lo} = {w_mul_sum, r_lo[WIDTH-1:1]};
            end
            OP_DIVU: begin
                // Non-negative trial difference means this quotient bit is 1
                if (!w_div_diff[WIDTH]) begin
                    w_step_hi = w_div_diff[WIDTH-1:0];
                    w_step_lo = {r_lo[WIDTH-2:0], 1'b1};
                end else begin
                    w_step_hi = w_div_rem[WIDTH-1:0];
                    w_step_lo = {r_lo[WIDTH-2:0], 1'b0};
                end
            end
            OP_SHIFTN: begin
                if (r_dir) begin
                    w_step_lo = {1'b0, r_lo[WIDTH-1:1]};
                    w_step_c  = r_lo[0];
                end else begin
                    w_step_lo = {r_lo[WIDTH-2:0], 1'b0};
                    w_step_c  = r_lo[WIDTH-1];
                end
            end
            default: ;
        endcase
    end

    // Iteration working registers; only meaningful while in RUN
    always_ff @(posedge clock) begin
        if (w_accept && w_multi) begin
            r_op   <= op;
            r_hi   <= '0;
            r_lo   <= (op == OP_DIVU) ? a : b;
            r_opnd <= (op == OP_MUL) ? a : b;
            r_dir  <= a[WIDTH-1];
            r_c    <= 1'b0;
            r_cnt  <= w_init_cnt;
        end else if (r_state == S_RUN) begin
            r_hi   <= w_step_hi;
            r_lo   <= w_step_lo;
            r_c    <= w_step_c;
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

    // Result selection: final iteration while in RUN, else the immediate op
    always_comb begin
        w_res_d        = '0;
        w_res_hi       = '0;
        w_res_carry    = 1'b0;
        w_res_low      = 1'b0;
        w_res_flag     = 1'b0;
        w_res_zero     = 1'b0;
        w_res_negative = 1'b0;
        if (r_state == S_RUN) begin
            case (r_op)
                OP_MUL: begin
                    w_res_d    = w_step_lo;
                    w_res_hi   = w_step_hi;
                    w_res_flag = (w_step_hi != '0);
                    w_res_zero = (w_step_hi == '0) && (w_step_lo == '0);
                end
                OP_DIVU: begin
                    w_res_d    = w_step_lo;
                    w_res_hi   = w_step_hi;
                    w_res_flag = (r_opnd == '0);
                    w_res_zero = (w_step_lo == '0);
                end
                OP_SHIFTN: begin
                    w_res_d     = w_step_lo;
                    w_res_carry = w_step_c;
                end
                default: ;
            endcase
        end else begin
            case (op)
                OP_ADD: begin
                    w_res_d     = w_add[WIDTH-1:0];
                    w_res_carry = w_add[WIDTH];
                    w_res_flag  = (a[WIDTH-1] == b[WIDTH-1]) &&
                                  (w_add[WIDTH-1] != a[WIDTH-1]);
                    w_res_zero  = (w_add[WIDTH-1:0] == '0);
                end
                OP_SUB: begin
                    w_res_d     = w_sub[WIDTH-1:0];
                    w_res_carry = w_sub[WIDTH];
                    w_res_flag  = (a[WIDTH-1] != b[WIDTH-1]) &&
                                  (w_sub[WIDTH-1] != a[WIDTH-1]);
                    w_res_zero  = (w_sub[WIDTH-1:0] == '0);
                end
                OP_CMP: begin
                    w_res_d        = w_sub[WIDTH-1:0];
                    w_res_zero     = (a == b);
                    w_res_low      = (a < b);
                    w_res_negative = ($signed(a) < $signed(b));
                end
                OP_AND: begin
                    w_res_d    = a & b;
                    w_res_zero = ((a & b) == '0);
                end
                OP_OR: begin
                    w_res_d    = a | b;
                    w_res_zero = ((a | b) == '0);
                end
                OP_XOR: begin
                    w_res_d    = a ^ b;
                    w_res_zero = ((a ^ b) == '0);
                end
                OP_SHIFT: begin
                    w_res_d    = a[0] ? {b[WIDTH-2:0], 1'b0} : {1'b0, b[WIDTH-1:1]};
                    w_res_zero = (w_res_d == '0);
                end
                OP_SHIFTN: begin
                    w_res_d = b;
                end
                default: ;
            endcase
        end
    end

    // Architectural outputs change only when an op completes
    always_ff @(posedge clock) begin
        if (reset) begin
            r_d        <= '0;
            r_d_hi     <= '0;
            r_carry    <= 1'b0;
            r_low      <= 1'b0;
            r_flag     <= 1'b0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
        end else if ((w_accept && !w_multi) || w_last) begin
            r_d        <= w_res_d;
            r_d_hi     <= w_res_hi;
            r_carry    <= w_res_carry;
            r_low      <= w_res_low;
            r_flag     <= w_res_flag;
            r_zero     <= w_res_zero;
            r_negative <= w_res_negative;
        end
    end

endmodule

// File: tb/tb_iterative_alu.sv
// Scoreboard bench for iterative_alu: driver pushes model results, monitor checks on done.
module tb_iterative_alu;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    op = 4'd0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          ready, done;
    logic [W-1:0]  d, d_hi;
    logic          carry, low, flag, zero, negative;

    iterative_alu #(.WIDTH(W)) dut (
        .clock(clk), .reset(rst), .start(start), .op(op), .a(a), .b(b),
        .ready(ready), .done(done), .d(d), .d_hi(d_hi),
        .carry(carry), .low(low), .flag(flag), .zero(zero), .negative(negative)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // flags packed as {carry, low, flag, zero, negative}
    typedef struct {
        logic [15:0] d;
        logic [15:0] dh;
        logic [4:0]  fl;
        int          n;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] last_d = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t        e;
        logic [16:0] s;
        logic [31:0] p;
        int          sx, sy, amt;
        e.d = '0; e.dh = '0; e.fl = '0; e.n = 0; e.due = 0;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            4'd0: begin
                s = {1'b0, x} + {1'b0, y};
                e.d = s[15:0];
                e.fl[4] = s[16];
                e.fl[2] = (sx + sy > 32767) || (sx + sy < -32768);
                e.fl[1] = (e.d == 0);
            end
            4'd1: begin
                e.d = x - y;
                e.fl[4] = (x < y);
                e.fl[2] = (sx - sy > 32767) || (sx - sy < -32768);
                e.fl[1] = (e.d == 0);
            end
            4'd2: begin
                e.d = x - y;
                e.fl[1] = (x == y);
                e.fl[3] = (x < y);
                e.fl[0] = (sx < sy);
            end
            4'd3: begin e.d = x & y; e.fl[1] = (e.d == 0); end
            4'd4: begin e.d = x | y; e.fl[1] = (e.d == 0); end
            4'd5: begin e.d = x ^ y; e.fl[1] = (e.d == 0); end
            4'd6: begin
                e.d = x[0] ? (y << 1) : (y >> 1);
                e.fl[1] = (e.d == 0);
            end
            4'd7: begin
                amt = int'(x[3:0]);
                e.n = amt;
                if (x[15]) begin
                    e.d = y >> amt;
                    if (amt > 0) e.fl[4] = y[amt-1];
                end else begin
                    e.d = y << amt;
                    if (amt > 0) e.fl[4] = y[16-amt];
                end
            end
            4'd8: begin
                p = {16'd0, x} * {16'd0, y};
                e.d = p[15:0];
                e.dh = p[31:16];
                e.fl[2] = (e.dh != 0);
                e.fl[1] = (p == 0);
                e.n = 16;
            end
            4'd9: begin
                e.n = 16;
                if (y == 0) begin
                    e.d = 16'hFFFF;
                    e.dh = x;
                    e.fl[2] = 1'b1;
                end else begin
                    e.d = x / y;
                    e.dh = x % y;
                    e.fl[1] = (e.d == 0);
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    // Wait for ready, present one request, push its expected response.
    task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) begin
            chk("ready_timeout", {31'd0, ready}, 32'd1);
            return;
        end
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        e = model(o, x, y);
        e.due = cyc + e.n;
        sb.push_back(e);
        start = 1'b0;
        op = 4'($urandom);
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {16'd0, d}, 32'hDEAD_0000);
            end else begin
                e = sb.pop_front();
                chk("d", {16'd0, d}, {16'd0, e.d});
                chk("d_hi", {16'd0, d_hi}, {16'd0, e.dh});
                chk("flags", {27'd0, carry, low, flag, zero, negative}, {27'd0, e.fl});
                chk("latency", 32'(cyc), 32'(e.due));
                last_d = e.d;
            end
        end
    end

    function automatic logic [15:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_d", {16'd0, d}, 32'd0);
        chk("rst_d_hi", {16'd0, d_hi}, 32'd0);
        chk("rst_flags", {27'd0, carry, low, flag, zero, negative}, 32'd0);
        rst = 1'b0;

        issue(4'd0, 16'h7FFF, 16'h0001);
        issue(4'd8, 16'h0123, 16'h0456);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("ready_low_in_run", {31'd0, ready}, 32'd0);
            if (i == 3) begin
                start = 1'b1; op = 4'd0; a = 16'h1111; b = 16'h2222;
            end else begin
                start = 1'b0;
            end
        end
        issue(4'd9, 16'h03E8, 16'h0007);
        issue(4'd9, 16'h1234, 16'h0000);
        issue(4'd7, 16'h0003, 16'h00F1);
        issue(4'd7, 16'h8004, 16'h00F1);
        issue(4'd7, 16'h0000, 16'h00F1);
        issue(4'd0, 16'hFFFF, 16'h0001);
        issue(4'd1, 16'h8000, 16'h0001);
        issue(4'd1, 16'h0000, 16'h0001);
        issue(4'd2, 16'h8000, 16'h0001);
        issue(4'd2, 16'h5A5A, 16'h5A5A);
        issue(4'd6, 16'h0001, 16'h8001);
        issue(4'd6, 16'h0000, 16'h0001);
        issue(4'd7, 16'h800F, 16'hC000);
        issue(4'd7, 16'h000F, 16'h0003);
        issue(4'd8, 16'hFFFF, 16'hFFFF);
        issue(4'd9, 16'h0005, 16'h0009);
        issue(4'd12, 16'h1234, 16'h5678);

        for (int k = 0; k < 300; k++) begin
            issue(4'($urandom_range(0, 15)), pick_val(), pick_val());
        end

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        chk("hold_after_done", {16'd0, d}, {16'd0, last_d});

        issue(4'd8, 16'h00FF, 16'h0101);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_d", {16'd0, d}, 32'd0);
        chk("abort_d_hi", {16'd0, d_hi}, 32'd0);
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
